seq_mult_param: RTL and testbench

- Parametrised sequential shift-add multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement (selected per operation), into a full 2*WIDTH-bit product.
- Uses a start/busy/done handshake with operands captured at start, so switch or bus inputs may change during the operation.
- Sits between board I/O (switches/buttons) or a datapath controller and the LED/result register, and serves as the general-width replacement for the fixed 4x4 lab multiplier.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/seq_mult_datapath.sv | 71 +++++++
 rtl/seq_mult_param.sv | 65 ++++++
 tb/tb_seq_mult_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared FSM encoding and operand-magnitude helper for the sequential multiplier.
package mult_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_FIX  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  // Magnitude of a w-bit value held in the low bits of x when en is set, else raw.
  // -2^(w-1) maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [31:0] abs_w(input logic [31:0] x, input int w, input logic en);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (en && x[w-1]) return (~x + 32'd1) & mask;
    return x & mask;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: one add/shift per step, sign fix-up into the product register.
// No flow control of its own; load/step/fix strobes come from the controlling FSM.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               fix_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH:0]   acc_q,   acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               neg_q,   neg_d;
  logic [2*WIDTH-1:0] prod_q,  prod_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    // Upper half is WIDTH+1 bits so the carry of the add survives into the shift.
    sum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    if (load_i) begin
      neg_d   = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      mcand_d = WIDTH'(abs_w(32'(a_i), WIDTH, signed_mode_i));
      acc_d   = {{(WIDTH+1){1'b0}}, WIDTH'(abs_w(32'(b_i), WIDTH, signed_mode_i))};
      cnt_d   = '0;
    end else if (step_i) begin
      acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (fix_i) begin
      prod_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));
  assign product_o = prod_q;

endmodule

// File: rtl/seq_mult_param.sv
// WIDTH x WIDTH sequential multiplier, unsigned or signed per op; WIDTH+2 cycles per op.
// start is a level request taken only when idle or in the final done cycle; never queued.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [ST_W-1:0] state_q, state_d;
  logic            load, step, fix, last;

  // A start sampled at the edge that closes DONE begins the next op directly,
  // giving one operation every WIDTH+2 cycles when start is held.
  assign load = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign step = (state_q == ST_RUN);
  assign fix  = (state_q == ST_FIX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  seq_mult_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .step_i       (step),
    .fix_i        (fix),
    .signed_mode_i(signed_mode),
    .a_i          (a),
    .b_i          (b),
    .last_o       (last),
    .product_o    (product)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param at WIDTH=4 and WIDTH=8 against a cycle-timed reference model.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  // Mathematical product of two w-bit operands, truncated to 2w bits.
  function automatic logic [15:0] ref_prod(input int w, input logic sm,
                                           input logic [7:0] a, input logic [7:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (64'sd1 <<< w);
    if (sm && b[w-1]) sb = sb - (64'sd1 <<< w);
    p = sa * sb;
    return 16'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  // Reference model: an op accepted at edge E is busy through edge E+w+1,
  // shows done after edge E+w+1, and frees the multiplier at edge E+w+2.
  int          cyc = 0;
  bit          model_ok = 1'b0;
  bit          m_active[2];
  int          m_e[2];
  int          m_acc[2];
  logic [15:0] m_prod[2];
  logic [15:0] m_pend[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_e[i] = 0; m_acc[i] = 0; m_prod[i] = '0; m_pend[i] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        int w;
        logic st, sm;
        logic [7:0] av, bv;
        w  = (i == 1) ? 8 : 4;
        st = (i == 1) ? start8 : start4;
        sm = (i == 1) ? sm8 : sm4;
        av = (i == 1) ? a8 : {4'b0, a4};
        bv = (i == 1) ? b8 : {4'b0, b4};
        if (!rst_n) begin
          m_active[i] = 1'b0;
          m_prod[i]   = '0;
          model_ok    = 1'b1;
        end else begin
          if (m_active[i] && cyc == m_e[i] + w + 1) m_prod[i] = m_pend[i];
          if (m_active[i] && cyc == m_e[i] + w + 2) m_active[i] = 1'b0;
          if (!m_active[i] && st) begin
            m_active[i] = 1'b1;
            m_e[i]      = cyc;
            m_pend[i]   = ref_prod(w, sm, av, bv);
            m_acc[i]++;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int dn[2];

  task automatic run_op(input int inst, input logic sm, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] exp, input int lat);
    int  n;
    bit  got;
    @(negedge clk);
    if (inst == 1) begin start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv; end
    else begin start4 = 1'b1; sm4 = sm; a4 = av[3:0]; b4 = bv[3:0]; end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    chk("busy_after_accept", (inst == 1) ? busy8 : busy4, 1);
    n = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (((inst == 1) ? done8 : done4) === 1'b1) got = 1'b1;
    end
    chk("done_latency", n, lat);
    chk("product_literal", (inst == 1) ? prod8 : {8'b0, prod4}, exp);
    @(negedge clk);
    chk("busy_after_done", (inst == 1) ? busy8 : busy4, 0);
    chk("done_one_cycle", (inst == 1) ? done8 : done4, 0);
  endtask

  initial begin
    int acc_before, dn_before;
    dn[0] = 0; dn[1] = 0;
    fork
      forever begin
        @(negedge clk);
        if (model_ok) begin
          if (done4 === 1'b1) dn[0]++;
          if (done8 === 1'b1) dn[1]++;
          chk("m4_busy", busy4, m_active[0]);
          chk("m4_done", done4, m_active[0] && cyc == m_e[0] + 5);
          chk("m4_product", prod4, m_prod[0]);
          chk("m8_busy", busy8, m_active[1]);
          chk("m8_done", done8, m_active[1] && cyc == m_e[1] + 9);
          chk("m8_product", prod8, m_prod[1]);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset_busy4", busy4, 0);
    chk("reset_done4", done4, 0);
    chk("reset_prod4", prod4, 0);
    chk("reset_prod8", prod8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=4 and WIDTH=8 vectors with hand-computed results.
    run_op(0, 1'b0, 8'd13, 8'd11, 16'd143, 5);
    run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, 5);
    run_op(0, 1'b1, 8'h08, 8'h07, 16'h00C8, 5);
    run_op(0, 1'b1, 8'h0F, 8'h00, 16'h0000, 5);
    run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
    run_op(1, 1'b1, 8'hFF, 8'hFF, 16'h0001, 9);
    run_op(1, 1'b1, 8'h80, 8'h7F, 16'hC080, 9);

    // start held high with operands changing mid-operation.
    acc_before = m_acc[1];
    dn_before  = dn[1];
    @(negedge clk);
    start8 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a8  = 8'(17 * k + 5);
      b8  = 8'(29 * k + 3);
      sm8 = ((k % 4) >= 2);
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_accepts", m_acc[1] - acc_before, 3);
    chk("held_dones", dn[1] - dn_before, 3);

    // Reset during the third iteration aborts without a done pulse.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_prod", prod8, 0);
    run_op(1, 1'b0, 8'd100, 8'd3, 16'd300, 9);

    // Full WIDTH=4 operand sweep in both modes.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_op(0, s[0], 8'(x), 8'(y), ref_prod(4, s[0], 8'(x), 8'(y)), 5);

    repeat (3) @(negedge clk);
    chk("done_vs_accept4", dn[0], m_acc[0]);
    chk("done_count4", dn[0], 516);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
